safe_code_ctrl: RTL and testbench



---
 rtl/safe_pkg.sv | 26 ++
 rtl/safe_code_ctrl_if.sv | 34 +++
 rtl/sec_tick_gen.sv | 35 +++
 rtl/safe_code_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_safe_code_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/safe_pkg.sv
// Shared types and constants for the safe lock configuration/supervision controller.
package safe_pkg;

  // Controller modes: normal, first programming pass, confirm pass, timed lockout.
  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_CONFIRM,
    S_LOCKOUT
  } state_t;

  // Bits needed to hold an index in 0..n-1 (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Index width for the standard three-button keypad.
  localparam int unsigned IW = idx_width(3);

  // Seconds of keypad inactivity tolerated while programming (optional timeout).
  localparam int unsigned PROG_TIMEOUT_S = 10;

  // One combination digit: a button index.
  typedef logic [IW-1:0] digit_t;

endpackage

// File: rtl/safe_code_ctrl_if.sv
// Button/lock-FSM side signals of the safe code controller.
// master: the source of buttons, programming switch and lock FSM status.
// slave:  the controller itself.
interface safe_code_ctrl_if #(
  parameter int unsigned NUM_BTN   = 3,
  parameter int unsigned CODE_LEN  = 3,
  parameter int unsigned MAX_FAILS = 3,
  parameter int unsigned LOCKOUT_S = 30
);

  logic [NUM_BTN-1:0]                              btn_pulse;
  logic                                            prog_req;
  logic                                            fsm_ok;
  logic                                            fsm_fail;
  logic [CODE_LEN*safe_pkg::idx_width(NUM_BTN)-1:0] code_o;
  logic                                            lock_en;
  logic                                            prog_active;
  logic                                            lockout;
  logic [$clog2(MAX_FAILS+1)-1:0]                  fail_cnt;
  logic [$clog2(LOCKOUT_S+1)-1:0]                  secs_left;
  logic                                            prog_done;
  logic                                            prog_err;

  modport master (
    output btn_pulse, prog_req, fsm_ok, fsm_fail,
    input  code_o, lock_en, prog_active, lockout, fail_cnt, secs_left, prog_done, prog_err
  );

  modport slave (
    input  btn_pulse, prog_req, fsm_ok, fsm_fail,
    output code_o, lock_en, prog_active, lockout, fail_cnt, secs_left, prog_done, prog_err
  );

endinterface

// File: rtl/sec_tick_gen.sv
// One-second tick generator: one-cycle tick every CLK_HZ cycles, restarted by clr.
module sec_tick_gen #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (CLK_HZ < 2) ? 1 : $clog2(CLK_HZ);
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Wrap at LAST; clr holds the count at zero so the next tick is a full period away.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST) && !clr;

endmodule

// File: rtl/safe_code_ctrl.sv
// Safe lock code controller: holds the active combination, runs two-pass programming
// (enter then confirm), counts consecutive failed unlocks and imposes a timed lockout.
// Optional build macro SAFE_PROG_TIMEOUT_EN: abort programming with prog_err after
// PROG_TIMEOUT_S seconds without a button press.
module safe_code_ctrl
  import safe_pkg::*;
#(
  parameter int unsigned NUM_BTN  = 3,
  parameter int unsigned CODE_LEN = 3,
  parameter logic [CODE_LEN*idx_width(NUM_BTN)-1:0] DEFAULT_CODE = {2'd2, 2'd1, 2'd0},
  parameter int unsigned MAX_FAILS = 3,
  parameter int unsigned LOCKOUT_S = 30,
  parameter int unsigned CLK_HZ    = 50_000_000
) (
  input logic             clk,
  input logic             rst_n,
  safe_code_ctrl_if.slave bus
);

  localparam int unsigned BW = idx_width(NUM_BTN);
  localparam int unsigned CW = CODE_LEN * BW;
  localparam int unsigned XW = idx_width(CODE_LEN);
  localparam int unsigned FW = $clog2(MAX_FAILS + 1);
  localparam int unsigned SW = $clog2(LOCKOUT_S + 1);

  state_t          state_q, state_d;
  logic            prog_req_q;
  logic [XW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   sh_a_q, sh_a_d;
  logic [CW-1:0]   sh_b_q, sh_b_d;
  logic [CW-1:0]   code_q, code_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic [SW-1:0]   secs_q, secs_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            tick, tick_clr;
  logic            in_prog, prog_timeout;
  logic            btn_any, btn_one, btn_multi;
  logic [BW-1:0]   btn_idx;

  assign in_prog   = (state_q == S_ENTRY) || (state_q == S_CONFIRM);
  assign btn_any   = |bus.btn_pulse;
  assign btn_one   = $onehot(bus.btn_pulse);
  assign btn_multi = btn_any && !btn_one;

  // Encode the pressed button to its index (meaningful only when exactly one is set).
  always_comb begin
    btn_idx = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (bus.btn_pulse[i]) begin
        btn_idx = BW'(i);
      end
    end
  end

`ifdef SAFE_PROG_TIMEOUT_EN
  localparam int unsigned TW = $clog2(PROG_TIMEOUT_S + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // Second timer restarts in idle (so entry starts fresh) and on every press.
  assign tick_clr = (state_q == S_IDLE) || (in_prog && btn_any);

  // Count whole seconds of keypad silence while programming.
  always_comb begin
    tmo_d = tmo_q;
    if (!in_prog || btn_any) begin
      tmo_d = '0;
    end else if (tick) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Silence-seconds register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign prog_timeout = in_prog && tick && !btn_any && (tmo_q == TW'(PROG_TIMEOUT_S - 1));
`else
  // Second timer only runs during lockout and restarts on every entry.
  assign tick_clr     = (state_q != S_LOCKOUT);
  assign prog_timeout = 1'b0;
`endif

  sec_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_sec_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tick_clr),
    .tick (tick)
  );

  // Mode sequencing, digit capture, commit, failure counting and lockout countdown.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    code_d  = code_q;
    fail_d  = fail_q;
    secs_d  = secs_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A fail that reaches the limit takes priority over starting programming.
        if (bus.fsm_fail && (fail_q >= FW'(MAX_FAILS - 1))) begin
          state_d = S_LOCKOUT;
          fail_d  = FW'(MAX_FAILS);
          secs_d  = SW'(LOCKOUT_S);
        end else begin
          if (bus.fsm_fail) begin
            fail_d = fail_q + 1'b1;
          end else if (bus.fsm_ok) begin
            fail_d = '0;
          end
          if (bus.prog_req && !prog_req_q) begin
            state_d = S_ENTRY;
            idx_d   = '0;
          end
        end
      end

      S_ENTRY, S_CONFIRM: begin
        if (!bus.prog_req) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (prog_timeout) begin
          state_d = S_IDLE;
          idx_d   = '0;
          err_d   = 1'b1;
        end else if (btn_multi) begin
          // Ambiguous press: throw away both passes and restart entry.
          state_d = S_ENTRY;
          idx_d   = '0;
          sh_a_d  = '0;
          sh_b_d  = '0;
          err_d   = 1'b1;
        end else if (btn_one) begin
          if (state_q == S_ENTRY) begin
            sh_a_d[idx_q*BW +: BW] = btn_idx;
          end else begin
            sh_b_d[idx_q*BW +: BW] = btn_idx;
          end
          idx_d = idx_q + 1'b1;
          if (idx_q == XW'(CODE_LEN - 1)) begin
            idx_d = '0;
            if (state_q == S_ENTRY) begin
              state_d = S_CONFIRM;
            end else begin
              state_d = S_IDLE;
              if (sh_b_d == sh_a_q) begin
                code_d = sh_a_q;
                done_d = 1'b1;
                fail_d = '0;
              end else begin
                err_d = 1'b1;
              end
            end
          end
        end
      end

      S_LOCKOUT: begin
        if (tick) begin
          if (secs_q <= SW'(1)) begin
            state_d = S_IDLE;
            secs_d  = '0;
            fail_d  = '0;
          end else begin
            secs_d = secs_q - 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; prog_req history starts high so a held switch
  // at reset release does not look like a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      prog_req_q <= 1'b1;
      idx_q      <= '0;
      sh_a_q     <= '0;
      sh_b_q     <= '0;
      code_q     <= DEFAULT_CODE;
      fail_q     <= '0;
      secs_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prog_req_q <= bus.prog_req;
      idx_q      <= idx_d;
      sh_a_q     <= sh_a_d;
      sh_b_q     <= sh_b_d;
      code_q     <= code_d;
      fail_q     <= fail_d;
      secs_q     <= secs_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.code_o      = code_q;
  assign bus.lock_en     = (state_q == S_IDLE);
  assign bus.prog_active = in_prog;
  assign bus.lockout     = (state_q == S_LOCKOUT);
  assign bus.fail_cnt    = fail_q;
  assign bus.secs_left   = secs_q;
  assign bus.prog_done   = done_q;
  assign bus.prog_err    = err_q;

endmodule

// File: tb/tb_safe_code_ctrl.sv
// Self-checking bench for safe_code_ctrl with a fast clock (CLK_HZ=10, LOCKOUT_S=3).
// A behavioural model predicts every output each cycle; directed literal checks pin it.
module tb_safe_code_ctrl;
  import safe_pkg::*;

  localparam int unsigned NB = 3;
  localparam int unsigned CL = 3;
  localparam int unsigned MF = 3;
  localparam int unsigned LS = 3;
  localparam int unsigned HZ = 10;
  localparam int unsigned BW = 2;
  localparam logic [5:0] DEF = 6'b10_01_00;
`ifdef SAFE_PROG_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  safe_code_ctrl_if #(
    .NUM_BTN(NB), .CODE_LEN(CL), .MAX_FAILS(MF), .LOCKOUT_S(LS)
  ) bus ();

  safe_code_ctrl #(
    .NUM_BTN(NB), .CODE_LEN(CL), .DEFAULT_CODE(DEF), .MAX_FAILS(MF), .LOCKOUT_S(LS),
    .CLK_HZ(HZ)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 normal, 1 entering, 2 confirming, 3 locked out
  int m_mode;
  int m_a[$];
  int m_b[$];
  int m_code[CL];
  int m_fail;
  int m_lock_cyc;
  int m_quiet;
  bit m_prev_req;
  bit m_done;
  bit m_err;

  task automatic m_reset();
    m_mode = 0;
    m_a.delete();
    m_b.delete();
    m_code = '{0, 1, 2};
    m_fail = 0;
    m_lock_cyc = 0;
    m_quiet = 0;
    m_prev_req = 1'b1;
    m_done = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic m_step();
    int nset = 0;
    int which = 0;
    bit req = bus.prog_req;
    bit same;
    for (int i = 0; i < NB; i++) begin
      if (bus.btn_pulse[i]) begin
        nset++;
        which = i;
      end
    end
    m_done = 1'b0;
    m_err = 1'b0;
    case (m_mode)
      0: begin
        if (bus.fsm_fail) begin
          m_fail++;
          if (m_fail >= MF) begin
            m_fail = MF;
            m_mode = 3;
            m_lock_cyc = 0;
          end
        end else if (bus.fsm_ok) begin
          m_fail = 0;
        end
        if (m_mode == 0 && req && !m_prev_req) begin
          m_mode = 1;
          m_a.delete();
          m_b.delete();
          m_quiet = 0;
        end
      end
      1, 2: begin
        if (nset != 0) m_quiet = 0;
        else m_quiet++;
        if (!req) begin
          m_mode = 0;
        end else if (TMO_EN && m_quiet >= int'(PROG_TIMEOUT_S * HZ)) begin
          m_mode = 0;
          m_err = 1'b1;
        end else if (nset > 1) begin
          m_err = 1'b1;
          m_mode = 1;
          m_a.delete();
          m_b.delete();
        end else if (nset == 1) begin
          if (m_mode == 1) begin
            m_a.push_back(which);
            if (m_a.size() == CL) m_mode = 2;
          end else begin
            m_b.push_back(which);
            if (m_b.size() == CL) begin
              m_mode = 0;
              same = 1'b1;
              for (int i = 0; i < CL; i++) if (m_a[i] != m_b[i]) same = 1'b0;
              if (same) begin
                for (int i = 0; i < CL; i++) m_code[i] = m_a[i];
                m_done = 1'b1;
                m_fail = 0;
              end else begin
                m_err = 1'b1;
              end
            end
          end
        end
      end
      default: begin
        m_lock_cyc++;
        if (m_lock_cyc >= int'(LS * HZ)) begin
          m_mode = 0;
          m_fail = 0;
          m_lock_cyc = 0;
        end
      end
    endcase
    m_prev_req = req;
  endtask

  function automatic logic [31:0] exp_code();
    logic [31:0] v = '0;
    for (int i = 0; i < CL; i++) v |= 32'(m_code[i]) << (i * BW);
    return v;
  endfunction

  task automatic compare_all();
    int secs = (m_mode == 3) ? int'(LS) - m_lock_cyc / int'(HZ) : 0;
    check("code_o", 32'(bus.code_o), exp_code());
    check("lock_en", 32'(bus.lock_en), 32'(m_mode == 0));
    check("prog_active", 32'(bus.prog_active), 32'(m_mode == 1 || m_mode == 2));
    check("lockout", 32'(bus.lockout), 32'(m_mode == 3));
    check("fail_cnt", 32'(bus.fail_cnt), 32'(m_fail));
    check("secs_left", 32'(bus.secs_left), 32'(secs));
    check("prog_done", 32'(bus.prog_done), 32'(m_done));
    check("prog_err", 32'(bus.prog_err), 32'(m_err));
  endtask

  // Model advances on each clock edge; outputs compared on the falling edge.
  initial begin
    m_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) m_reset();
      else m_step();
      @(negedge clk);
      if (!rst_n) m_reset();
      compare_all();
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [NB-1:0] b);
    bus.btn_pulse = b;
    cyc(1);
    bus.btn_pulse = '0;
  endtask

  task automatic fpulse(input logic ok, input logic fail);
    bus.fsm_ok = ok;
    bus.fsm_fail = fail;
    cyc(1);
    bus.fsm_ok = 1'b0;
    bus.fsm_fail = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  initial begin
    bus.btn_pulse = '0;
    bus.prog_req = 1'b1;
    bus.fsm_ok = 1'b0;
    bus.fsm_fail = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    // Reset values; a switch already high at release must not start programming.
    check("rst code_o", 32'(bus.code_o), 32'(6'b10_01_00));
    check("rst lock_en", 32'(bus.lock_en), 32'd1);
    check("rst fail_cnt", 32'(bus.fail_cnt), 32'd0);
    check("rst secs_left", 32'(bus.secs_left), 32'd0);
    check("rst no prog", 32'(bus.prog_active), 32'd0);
    bus.prog_req = 1'b0;
    cyc(1);

    // Successful programming of 2,0,1.
    bus.prog_req = 1'b1;
    cyc(1);
    check("prog entered", 32'(bus.prog_active), 32'd1);
    press(3'b100); press(3'b001); press(3'b010);
    press(3'b100); press(3'b001); press(3'b010);
    check("prog_done pulse", 32'(bus.prog_done), 32'd1);
    check("new code", 32'(bus.code_o), 32'(6'b01_00_10));
    cyc(1);
    check("prog_done one cycle", 32'(bus.prog_done), 32'd0);
    check("lock_en after commit", 32'(bus.lock_en), 32'd1);
    bus.prog_req = 1'b0;
    cyc(1);

    // Confirm mismatch: 1,1,1 then 1,1,0.
    bus.prog_req = 1'b1;
    cyc(1);
    press(3'b010); press(3'b010); press(3'b010);
    press(3'b010); press(3'b010); press(3'b001);
    check("mismatch prog_err", 32'(bus.prog_err), 32'd1);
    check("mismatch code kept", 32'(bus.code_o), 32'(6'b01_00_10));
    check("mismatch idle", 32'(bus.lock_en), 32'd1);
    bus.prog_req = 1'b0;
    cyc(1);

    // Multi-bit press restarts entry, then abort during confirm.
    bus.prog_req = 1'b1;
    cyc(1);
    press(3'b010);
    press(3'b011);
    check("multi prog_err", 32'(bus.prog_err), 32'd1);
    check("multi stays prog", 32'(bus.prog_active), 32'd1);
    press(3'b001); press(3'b001); press(3'b001);
    check("in confirm", 32'(bus.prog_active), 32'd1);
    press(3'b001); press(3'b001);
    bus.prog_req = 1'b0;
    cyc(1);
    check("abort idle", 32'(bus.lock_en), 32'd1);
    check("abort no err", 32'(bus.prog_err), 32'd0);
    check("abort no done", 32'(bus.prog_done), 32'd0);
    cyc(2);

    // Failure counting, ok clears, simultaneous ok+fail counts as fail.
    fpulse(1'b0, 1'b1);
    fpulse(1'b0, 1'b1);
    check("fail_cnt 2", 32'(bus.fail_cnt), 32'd2);
    fpulse(1'b1, 1'b0);
    check("ok clears", 32'(bus.fail_cnt), 32'd0);
    fpulse(1'b0, 1'b1);
    fpulse(1'b1, 1'b1);
    check("both is fail", 32'(bus.fail_cnt), 32'd2);
    fpulse(1'b0, 1'b1);
    check("lockout on", 32'(bus.lockout), 32'd1);
    check("lockout lock_en", 32'(bus.lock_en), 32'd0);
    check("lockout secs 3", 32'(bus.secs_left), 32'd3);
    check("lockout fail max", 32'(bus.fail_cnt), 32'd3);
    // Inputs ignored during lockout; switch left high must not start programming later.
    press(3'b001);
    bus.prog_req = 1'b1;
    fpulse(1'b1, 1'b0);
    cyc(3);
    check("secs 3 mid", 32'(bus.secs_left), 32'd3);
    cyc(10);
    check("secs 2", 32'(bus.secs_left), 32'd2);
    cyc(10);
    check("secs 1", 32'(bus.secs_left), 32'd1);
    for (int i = 0; i < 20 && bus.lockout; i++) cyc(1);
    check("lockout exit", 32'(bus.lockout), 32'd0);
    check("exit fail_cnt", 32'(bus.fail_cnt), 32'd0);
    check("exit lock_en", 32'(bus.lock_en), 32'd1);
    check("exit no prog", 32'(bus.prog_active), 32'd0);
    bus.prog_req = 1'b0;
    cyc(1);

    // Reset while locked out.
    fpulse(1'b0, 1'b1); fpulse(1'b0, 1'b1); fpulse(1'b0, 1'b1);
    check("relock", 32'(bus.lockout), 32'd1);
    cyc(4);
    rst_n = 1'b0;
    #1;
    check("async rst lockout", 32'(bus.lockout), 32'd0);
    check("async rst lock_en", 32'(bus.lock_en), 32'd1);
    check("async rst code", 32'(bus.code_o), 32'(6'b10_01_00));
    check("async rst secs", 32'(bus.secs_left), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    // Programming inactivity.
    bus.prog_req = 1'b1;
    cyc(1);
    press(3'b001);
`ifdef SAFE_PROG_TIMEOUT_EN
    cyc(99);
    check("tmo still prog", 32'(bus.prog_active), 32'd1);
    cyc(1);
    check("tmo prog_err", 32'(bus.prog_err), 32'd1);
    check("tmo idle", 32'(bus.lock_en), 32'd1);
`else
    cyc(150);
    check("no tmo prog", 32'(bus.prog_active), 32'd1);
`endif
    bus.prog_req = 1'b0;
    cyc(2);
    check("final idle", 32'(bus.lock_en), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
